// File: rtl/mw_cook_controller_if.sv
// Front-panel bundle for the microwave cook controller.
// Carries the button levels, door switch, keypad strobe/digit and power
// selection into the controller. It carries the BCD time digits and the
// magnetron, beep and status flags back out to the panel.
//   master : panel/board side (drives inputs, observes outputs)
//   slave  : controller side
interface mw_cook_controller_if;
    logic       startn;
    logic       stopn;
    logic       door_closed;
    logic       key_valid;
    logic [3:0] key_digit;
    logic [3:0] power_sel;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       mag_on;
    logic       beep;
    logic       running;
    logic       paused;

    modport master (
        output startn, stopn, door_closed, key_valid, key_digit, power_sel,
        input  min_tens, min_ones, sec_tens, sec_ones,
        input  mag_on, beep, running, paused
    );

    modport slave (
        input  startn, stopn, door_closed, key_valid, key_digit, power_sel,
        output min_tens, min_ones, sec_tens, sec_ones,
        output mag_on, beep, running, paused
    );
endinterface

// File: rtl/mw_cook_controller.sv
// Microwave cook controller: keypad BCD time entry, 1 s tick divider,
// mm:ss BCD countdown, power-level duty cycler and cook/pause/done sequencing.
// Ports:
//   clk    system clock, rising edge
//   rstn   asynchronous active-low reset
//   panel  front-panel bundle (slave side): buttons, door, keypad, power
//          select in; BCD digits, mag_on, beep, running, paused out
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no time entered, digits 0000
// ENTRY  | keypad digits being shifted in
// COOK   | counting down, magnetron duty-cycled by power level
// PAUSE  | cook suspended (door or stop), divider and duty counter held
// DONE   | time expired, beeping for BEEP_SECS ticks
module mw_cook_controller #(
    parameter int TICK_DIV   = 100,
    parameter int PWR_PERIOD = 10,
    parameter int BEEP_SECS  = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    mw_cook_controller_if.slave  panel
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int PW = $clog2(PWR_PERIOD + 1);
    localparam int BW = $clog2(BEEP_SECS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_COOK,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    mt_q, mo_q, st_q, so_q;
    logic [3:0]    mt_d, mo_d, st_d, so_d;
    logic [3:0]    dec_mt, dec_mo, dec_st, dec_so;
    logic [TW-1:0] tick_q, tick_d;
    logic [PW-1:0] pwr_q, pwr_d;
    logic [PW-1:0] lvl_q, lvl_d;
    logic [BW-1:0] bcnt_q, bcnt_d;

    logic start_q1, start_q2, stop_q1, stop_q2, door_q;
    logic start_press, stop_press, door_fall;
    logic tick, time_nz, dec_zero;

    // Buttons are synchronised once, then edge-detected on the registered
    // copy, so a press acts one cycle after it is first sampled.
    assign start_press = start_q2 & ~start_q1;
    assign stop_press  = stop_q2 & ~stop_q1;
    assign door_fall   = door_q & ~panel.door_closed;

    assign tick     = (tick_q == TW'(TICK_DIV - 1));
    assign time_nz  = ({mt_q, mo_q, st_q, so_q} != 16'h0000);
    assign dec_zero = ({dec_mt, dec_mo, dec_st, dec_so} == 16'h0000);

    // One-second BCD decrement; seconds borrow to 5 from minutes, so entered
    // values above 59 s simply count down through the tens digit.
    always_comb begin
        dec_mt = mt_q;
        dec_mo = mo_q;
        dec_st = st_q;
        dec_so = so_q;
        if (so_q != 4'd0) begin
            dec_so = so_q - 4'd1;
        end else begin
            dec_so = 4'd9;
            if (st_q != 4'd0) begin
                dec_st = st_q - 4'd1;
            end else begin
                dec_st = 4'd5;
                if (mo_q != 4'd0) begin
                    dec_mo = mo_q - 4'd1;
                end else begin
                    dec_mo = 4'd9;
                    dec_mt = mt_q - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mo_d    = mo_q;
        st_d    = st_q;
        so_d    = so_q;
        tick_d  = tick_q;
        pwr_d   = pwr_q;
        lvl_d   = lvl_q;
        bcnt_d  = bcnt_q;

        case (state_q)
            S_IDLE, S_ENTRY: begin
                if (stop_press) begin
                    state_d = S_IDLE;
                    mt_d = 4'd0;
                    mo_d = 4'd0;
                    st_d = 4'd0;
                    so_d = 4'd0;
                end else if (start_press && time_nz && panel.door_closed) begin
                    state_d = S_COOK;
                    tick_d  = '0;
                    pwr_d   = '0;
                    if (panel.power_sel == 4'd0 || 32'(panel.power_sel) > PWR_PERIOD) begin
                        lvl_d = PW'(PWR_PERIOD);
                    end else begin
                        lvl_d = PW'(panel.power_sel);
                    end
                end else if (panel.key_valid && panel.key_digit <= 4'd9) begin
                    state_d = S_ENTRY;
                    mt_d = mo_q;
                    mo_d = st_q;
                    st_d = so_q;
                    so_d = panel.key_digit;
                end
            end

            S_COOK: begin
                if (stop_press || !panel.door_closed) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    tick_d = '0;
                    pwr_d  = (pwr_q == PW'(PWR_PERIOD - 1)) ? '0 : pwr_q + PW'(1);
                    mt_d = dec_mt;
                    mo_d = dec_mo;
                    st_d = dec_st;
                    so_d = dec_so;
                    if (dec_zero) begin
                        state_d = S_DONE;
                        bcnt_d  = '0;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end

            S_PAUSE: begin
                if (stop_press) begin
                    state_d = S_IDLE;
                    mt_d = 4'd0;
                    mo_d = 4'd0;
                    st_d = 4'd0;
                    so_d = 4'd0;
                end else if (start_press && panel.door_closed) begin
                    state_d = S_COOK;
                end
            end

            S_DONE: begin
                if (stop_press || door_fall) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    tick_d = '0;
                    if (bcnt_q == BW'(BEEP_SECS - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            mt_q     <= 4'd0;
            mo_q     <= 4'd0;
            st_q     <= 4'd0;
            so_q     <= 4'd0;
            tick_q   <= '0;
            pwr_q    <= '0;
            lvl_q    <= '0;
            bcnt_q   <= '0;
            start_q1 <= 1'b1;
            start_q2 <= 1'b1;
            stop_q1  <= 1'b1;
            stop_q2  <= 1'b1;
            door_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mt_q     <= mt_d;
            mo_q     <= mo_d;
            st_q     <= st_d;
            so_q     <= so_d;
            tick_q   <= tick_d;
            pwr_q    <= pwr_d;
            lvl_q    <= lvl_d;
            bcnt_q   <= bcnt_d;
            start_q1 <= panel.startn;
            start_q2 <= start_q1;
            stop_q1  <= panel.stopn;
            stop_q2  <= stop_q1;
            door_q   <= panel.door_closed;
        end
    end

    assign panel.min_tens = mt_q;
    assign panel.min_ones = mo_q;
    assign panel.sec_tens = st_q;
    assign panel.sec_ones = so_q;
    assign panel.running  = (state_q == S_COOK);
    assign panel.paused   = (state_q == S_PAUSE);
    assign panel.beep     = (state_q == S_DONE);
    // Combinational so the magnetron drops the instant the door opens.
    assign panel.mag_on   = (state_q == S_COOK) & panel.door_closed & (pwr_q < lvl_q);
endmodule
